// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix receive controller.
//   state_t     : controller FSM states
//   size_log2n  : maps the 2-bit size code to log2 of the matrix dimension
//   ADDR_W, DATA_W, RES_W, MAX_MATRICES, CNT_W, IDX_W : widths and limits
package matrix_pkg;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 8;
  localparam int RES_W        = 50;
  localparam int IDX_W        = 5;
  localparam int MAX_MATRICES = 32;
  // One extra bit so the count can reach 32*16*16 without wrapping.
  localparam int CNT_W        = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT_Q = 3'd2,
    QRY    = 3'd3,
    BUSY   = 3'd4,
    OUT    = 3'd5
  } state_t;

  // Size code 0..3 selects N = 2, 4, 8, 16.
  function automatic logic [2:0] size_log2n(input logic [1:0] code);
    return {1'b0, code} + 3'd1;
  endfunction

endpackage

// File: rtl/matrix_rx_ctrl_if.sv
// Handshake bundle between the pattern stream, the matrix SRAM, the compute
// core and the result port of matrix_rx_ctrl.
//   slave  : controller view (stream/done/result in, SRAM/query/result out)
//   master : environment view (the mirror image)
interface matrix_rx_ctrl_if;
  import matrix_pkg::*;

  logic                     in_valid;
  logic [DATA_W-1:0]        matrix;
  logic [1:0]               matrix_size;
  logic                     in_valid2;
  logic [IDX_W-1:0]         matrix_idx;
  logic [1:0]               mode;

  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [1:0]               size_q;

  logic                     start;
  logic [IDX_W-1:0]         idx0;
  logic [IDX_W-1:0]         idx1;
  logic [IDX_W-1:0]         idx2;
  logic [1:0]               mode_q;
  logic                     done;
  logic signed [RES_W-1:0]  result;

  logic                     out_valid;
  logic signed [RES_W-1:0]  out_value;

  modport slave (
    input  in_valid, matrix, matrix_size, in_valid2, matrix_idx, mode, done, result,
    output mem_we, mem_addr, mem_wdata, size_q, start, idx0, idx1, idx2, mode_q,
           out_valid, out_value
  );

  modport master (
    output in_valid, matrix, matrix_size, in_valid2, matrix_idx, mode, done, result,
    input  mem_we, mem_addr, mem_wdata, size_q, start, idx0, idx1, idx2, mode_q,
           out_valid, out_value
  );

endinterface

// File: rtl/matrix_rx_ctrl.sv
// Front-end protocol controller of the matrix unit: stores the incoming
// matrix stream into SRAM, captures 3-beat index/mode queries, launches the
// compute core and returns its result as a single-cycle out_valid pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : matrix_rx_ctrl_if.slave (stream in, SRAM write, compute, result)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for the first matrix beat
// LOAD   | matrix beats streaming into SRAM
// WAIT_Q | set loaded; waiting for a query or a fresh matrix set
// QRY    | collecting query beats 2 and 3
// BUSY   | compute core running; stream inputs ignored
// OUT    | result presented for exactly one cycle
module matrix_rx_ctrl
  import matrix_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  matrix_rx_ctrl_if.slave bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        beat_limit;
  logic [1:0]              qry_beat;
  logic signed [RES_W-1:0] res_q;
  logic                    load_first;
  logic                    query_first;

  // Capacity is 32 matrices of N*N elements; later beats are discarded.
  assign beat_limit  = CNT_W'(MAX_MATRICES) << {size_log2n(bus.size_q), 1'b0};
  assign load_first  = bus.in_valid && (state == IDLE || state == WAIT_Q);
  // A new matrix set wins over a query arriving in the same cycle.
  assign query_first = (state == WAIT_Q) && !bus.in_valid && bus.in_valid2;

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = LOAD;
      LOAD:    if (!bus.in_valid) state_nxt = WAIT_Q;
      WAIT_Q: begin
        if (bus.in_valid)       state_nxt = LOAD;
        else if (bus.in_valid2) state_nxt = QRY;
      end
      QRY: begin
        if (!bus.in_valid2)        state_nxt = WAIT_Q;
        else if (qry_beat == 2'd2) state_nxt = BUSY;
      end
      BUSY:    if (bus.done) state_nxt = OUT;
      OUT:     state_nxt = WAIT_Q;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == OUT);
    bus.out_value = (state == OUT) ? res_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      beat_cnt      <= '0;
      qry_beat      <= '0;
      res_q         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.size_q    <= '0;
      bus.start     <= 1'b0;
      bus.idx0      <= '0;
      bus.idx1      <= '0;
      bus.idx2      <= '0;
      bus.mode_q    <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.start  <= 1'b0;

      if (load_first) begin
        bus.size_q    <= bus.matrix_size;
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= '0;
        bus.mem_wdata <= bus.matrix;
        beat_cnt      <= CNT_W'(1);
      end else if (state == LOAD && bus.in_valid && beat_cnt < beat_limit) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= beat_cnt[ADDR_W-1:0];
        bus.mem_wdata <= bus.matrix;
        beat_cnt      <= beat_cnt + CNT_W'(1);
      end

      if (query_first) begin
        bus.idx0   <= bus.matrix_idx;
        bus.mode_q <= bus.mode;
        qry_beat   <= 2'd1;
      end else if (state == QRY && bus.in_valid2) begin
        if (qry_beat == 2'd1) begin
          bus.idx1 <= bus.matrix_idx;
          qry_beat <= 2'd2;
        end else begin
          bus.idx2  <= bus.matrix_idx;
          bus.start <= 1'b1;
          qry_beat  <= 2'd0;
        end
      end

      if (state == BUSY && bus.done) res_q <= bus.result;
    end
  end

endmodule

// File: tb/tb_matrix_rx_ctrl.sv
module tb_matrix_rx_ctrl;
  import matrix_pkg::*;

  typedef struct {
    int                unsigned due;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int unsigned              due;
    logic signed [RES_W-1:0]  val;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  wr_t         wq[$];
  res_t        oq[$];
  wr_t         w_e;
  res_t        o_e;

  matrix_rx_ctrl_if bus();

  matrix_rx_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: writes and results are popped as the DUT emits them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          chk("write_unexpected", 64'(bus.mem_we), 64'd0);
        end else begin
          w_e = wq.pop_front();
          chk("write_cycle", 64'(cyc), 64'(w_e.due));
          chk("write_addr", 64'(bus.mem_addr), 64'(w_e.addr));
          chk("write_data", 64'(bus.mem_wdata), 64'(w_e.data));
        end
      end else if (wq.size() > 0 && wq[0].due <= cyc) begin
        chk("write_missing", 64'(bus.mem_we), 64'd1);
        w_e = wq.pop_front();
      end

      if (bus.out_valid) begin
        if (oq.size() == 0) begin
          chk("out_unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          o_e = oq.pop_front();
          chk("out_cycle", 64'(cyc), 64'(o_e.due));
          chk("out_value", 64'(bus.out_value), 64'(o_e.val));
        end
      end else begin
        chk("out_zero", 64'(bus.out_value), 64'd0);
        if (oq.size() > 0 && oq[0].due <= cyc) begin
          chk("out_missing", 64'(bus.out_valid), 64'd1);
          o_e = oq.pop_front();
        end
      end
    end
  end

  task automatic load(input logic [1:0] sz, input int n, input int extra);
    for (int i = 0; i < n + extra; i++) begin
      bus.in_valid    = 1'b1;
      bus.matrix      = 8'(i);
      bus.matrix_size = (i == 0) ? sz : (sz ^ 2'(i));
      if (i < n) wq.push_back('{cyc + 1, ADDR_W'(i), 8'(i)});
      tick();
      if (sz == 2'd0 && i == 20) chk("m5_base_addr", 64'(bus.mem_addr), 64'd20);
      if (i == n - 1) chk("last_addr", 64'(bus.mem_addr), 64'(n - 1));
      if (i >= n) chk("drop_we", 64'(bus.mem_we), 64'd0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("size_q", 64'(bus.size_q), 64'(sz));
  endtask

  task automatic query(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [1:0] m, input logic signed [RES_W-1:0] res,
                       input int delay, input bit poke);
    bus.in_valid2  = 1'b1;
    bus.matrix_idx = a;
    bus.mode       = m;
    tick();
    bus.matrix_idx = b;
    bus.mode       = ~m;
    tick();
    bus.matrix_idx = c;
    bus.mode       = 2'($urandom);
    tick();
    bus.in_valid2  = 1'b0;
    bus.matrix_idx = '0;
    chk("start_pulse", 64'(bus.start), 64'd1);
    chk("idx0", 64'(bus.idx0), 64'(a));
    chk("idx1", 64'(bus.idx1), 64'(b));
    chk("idx2", 64'(bus.idx2), 64'(c));
    chk("mode_q", 64'(bus.mode_q), 64'(m));
    tick();
    chk("start_one_cycle", 64'(bus.start), 64'd0);
    for (int d = 0; d < delay; d++) begin
      if (poke) begin
        bus.in_valid  = 1'b1;
        bus.in_valid2 = 1'b1;
        bus.matrix    = 8'hA5;
      end
      tick();
      chk("start_quiet_busy", 64'(bus.start), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.in_valid2 = 1'b0;
    bus.done      = 1'b1;
    bus.result    = res;
    oq.push_back('{cyc + 1, res});
    tick();
    bus.done   = 1'b0;
    bus.result = RES_W'($urandom);
    tick();
    chk("idx0_hold", 64'(bus.idx0), 64'(a));
    chk("mode_q_hold", 64'(bus.mode_q), 64'(m));
  endtask

  initial begin
    logic [4:0]              qa, qb, qc;
    logic [1:0]              qm;
    logic signed [RES_W-1:0] qr;

    bus.in_valid    = 1'b0;
    bus.matrix      = '0;
    bus.matrix_size = '0;
    bus.in_valid2   = 1'b0;
    bus.matrix_idx  = '0;
    bus.mode        = '0;
    bus.done        = 1'b0;
    bus.result      = '0;
    rst_n           = 1'b1;
    tick(3);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_value", 64'(bus.out_value), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_start", 64'(bus.start), 64'd0);
    rst_n  = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("idle_mem_we", 64'(bus.mem_we), 64'd0);
    chk("idle_size_q", 64'(bus.size_q), 64'd0);

    load(2'd0, 128, 0);
    load(2'd3, 8192, 2);

    // done outside BUSY must not produce a result
    bus.done   = 1'b1;
    bus.result = 50'sd123;
    tick();
    bus.done = 1'b0;
    chk("done_ignored_waitq", 64'(bus.out_valid), 64'd0);
    tick();

    query(5'd3, 5'd7, 5'd31, 2'd2, -50'sd5, 3, 1'b1);

    // query abandoned after two beats: no launch
    bus.in_valid2  = 1'b1;
    bus.matrix_idx = 5'd9;
    bus.mode       = 2'd1;
    tick();
    bus.matrix_idx = 5'd10;
    tick();
    bus.in_valid2 = 1'b0;
    tick();
    chk("short_qry_no_start", 64'(bus.start), 64'd0);
    tick();
    chk("short_qry_no_start2", 64'(bus.start), 64'd0);
    chk("short_qry_idx0", 64'(bus.idx0), 64'd9);

    for (int k = 0; k < 10; k++) begin
      qa = 5'($urandom);
      qb = 5'($urandom);
      qc = 5'($urandom);
      qm = 2'($urandom);
      qr = {$urandom, $urandom};
      query(qa, qb, qc, qm, qr, k % 4, 1'b0);
    end

    load(2'd1, 10, 0);

    // reset while BUSY: no result, later done ignored
    bus.in_valid2  = 1'b1;
    bus.matrix_idx = 5'd1;
    bus.mode       = 2'd3;
    tick();
    bus.matrix_idx = 5'd2;
    tick();
    bus.matrix_idx = 5'd4;
    tick();
    bus.in_valid2 = 1'b0;
    chk("busy_start", 64'(bus.start), 64'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("rst_busy_start", 64'(bus.start), 64'd0);
    chk("rst_busy_idx0", 64'(bus.idx0), 64'd0);
    chk("rst_busy_mode_q", 64'(bus.mode_q), 64'd0);
    chk("rst_busy_size_q", 64'(bus.size_q), 64'd0);
    chk("rst_busy_out_valid", 64'(bus.out_valid), 64'd0);
    bus.done   = 1'b1;
    bus.result = 50'sd77;
    tick();
    bus.done = 1'b0;
    chk("late_done_out_valid", 64'(bus.out_valid), 64'd0);
    chk("late_done_out_value", 64'(bus.out_value), 64'd0);
    tick();

    load(2'd2, 5, 0);
    tick(2);

    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("results_drained", 64'(oq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
